// File: rtl/suave_pkg.sv
// Shared constants and types for the writeback / register-file slice.
package suave_pkg;

    localparam int NUM_REGS = 32;
    localparam int CNT_MAX  = 3;

    // W-stage result selector encoding
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters with a two-source stall query.
// A pending write that retires in the current cycle is treated as covered,
// because the register file bypasses the W result to the D-stage readers.
module reg_scoreboard #(
    parameter int REGISTER_WIDTH = 5,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid_i,
    input  logic [REGISTER_WIDTH-1:0] issue_rd_i,
    input  logic                      wb_valid_i,
    input  logic [REGISTER_WIDTH-1:0] wb_rd_i,
    input  logic                      squash_i,
    input  logic [REGISTER_WIDTH-1:0] squash_rd_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_i,
    output logic                      stall_o
);

    localparam int NREGS = 2 ** REGISTER_WIDTH;
    localparam int SW    = CNT_WIDTH + 2;
    // Offset keeps the signed range -2..+1 of the net change non-negative.
    localparam logic [SW-1:0]        SUM_OFS = SW'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};
    localparam logic [SW-1:0]        SUM_TOP = SUM_OFS + SW'(CNT_SAT);

    logic [CNT_WIDTH-1:0] cnt_q [NREGS];
    logic [CNT_WIDTH-1:0] cnt_d [NREGS];
    logic                 inc;
    logic                 dec_w;
    logic                 dec_s;
    logic [SW-1:0]        sum;
    logic                 ovf;
    logic                 unf;
    logic                 hit1;
    logic                 hit2;
    logic [CNT_WIDTH-1:0] eff1;
    logic [CNT_WIDTH-1:0] eff2;

    // Next counter values: issue, retire and squash combine arithmetically, clamped at both ends.
    always_comb begin
        ovf   = 1'b0;
        unf   = 1'b0;
        inc   = 1'b0;
        dec_w = 1'b0;
        dec_s = 1'b0;
        sum   = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc   = issue_valid_i && (issue_rd_i == REGISTER_WIDTH'(r));
            dec_w = wb_valid_i && (wb_rd_i == REGISTER_WIDTH'(r));
            dec_s = squash_i && (squash_rd_i == REGISTER_WIDTH'(r));
            sum   = SW'(cnt_q[r]) + SUM_OFS + SW'(inc) - SW'(dec_w) - SW'(dec_s);
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (sum < SUM_OFS) begin
                    cnt_d[r] = '0;
                    unf      = 1'b1;
                end else if (sum > SUM_TOP) begin
                    cnt_d[r] = CNT_SAT;
                    ovf      = 1'b1;
                end else begin
                    cnt_d[r] = CNT_WIDTH'(sum - SUM_OFS);
                end
            end
        end
    end

    // Counter state; reset clears every entry regardless of what is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stall query: outstanding writes minus the one retiring (and bypassed) this cycle.
    always_comb begin
        hit1    = wb_valid_i && (wb_rd_i == rs1_i);
        hit2    = wb_valid_i && (wb_rd_i == rs2_i);
        eff1    = cnt_q[rs1_i] - CNT_WIDTH'(hit1);
        eff2    = cnt_q[rs2_i] - CNT_WIDTH'(hit2);
        stall_o = ((rs1_i != '0) && (eff1 != '0)) ||
                  ((rs2_i != '0) && (eff2 != '0));
    end

    // More writers in flight than pipeline stages, or a retire/squash with nothing outstanding.
    a_cnt_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !ovf);
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !unf);

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32-entry register file with write-first
// bypass on both D-stage read ports, and the in-flight write scoreboard.
module writeback_regfile
    import suave_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int CNT_WIDTH      = $clog2(CNT_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_write_w_i,
    input  logic [1:0]                result_src_w_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_w_i,
    input  logic [DATA_WIDTH-1:0]     read_data_w_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_w_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_w_i,
    input  logic [REGISTER_WIDTH-1:0] rd_w_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
    output logic [DATA_WIDTH-1:0]     rd1_d_o,
    output logic [DATA_WIDTH-1:0]     rd2_d_o,
    input  logic                      issue_valid_d_i,
    input  logic [REGISTER_WIDTH-1:0] issue_rd_d_i,
    input  logic                      squash_e_i,
    input  logic [REGISTER_WIDTH-1:0] squash_rd_e_i,
    output logic [DATA_WIDTH-1:0]     result_w_o,
    output logic                      stall_d_o
);

    localparam int NREGS = 2 ** REGISTER_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic                  wr_en;

    // W-stage result select
    always_comb begin
        result_w_o = alu_result_w_i;
        case (result_src_e'(result_src_w_i))
            RES_ALU: result_w_o = alu_result_w_i;
            RES_MEM: result_w_o = read_data_w_i;
            RES_PC4: result_w_o = pc_plus4_w_i;
            RES_IMM: result_w_o = imm_ext_w_i;
            default: result_w_o = alu_result_w_i;
        endcase
    end

    // Next register-file contents; writes to x0 are dropped.
    always_comb begin
        wr_en  = reg_write_w_i && (rd_w_i != '0);
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd_w_i] = result_w_o;
        end
    end

    // Register-file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // D-stage read ports: x0 reads zero, a same-cycle W write wins over the array.
    always_comb begin
        if (rs1_d_i == '0) begin
            rd1_d_o = '0;
        end else if (reg_write_w_i && (rd_w_i == rs1_d_i)) begin
            rd1_d_o = result_w_o;
        end else begin
            rd1_d_o = regs_q[rs1_d_i];
        end

        if (rs2_d_i == '0) begin
            rd2_d_o = '0;
        end else if (reg_write_w_i && (rd_w_i == rs2_d_i)) begin
            rd2_d_o = result_w_o;
        end else begin
            rd2_d_o = regs_q[rs2_d_i];
        end
    end

    reg_scoreboard #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid_d_i),
        .issue_rd_i    (issue_rd_d_i),
        .wb_valid_i    (reg_write_w_i),
        .wb_rd_i       (rd_w_i),
        .squash_i      (squash_e_i),
        .squash_rd_i   (squash_rd_e_i),
        .rs1_i         (rs1_d_i),
        .rs2_i         (rs2_d_i),
        .stall_o       (stall_d_o)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_w, mem_w, pc4_w, imm_w;
    logic [4:0]  rd_w, rs1_d, rs2_d;
    logic [31:0] rd1_d, rd2_d, result_w;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        squash_e;
    logic [4:0]  squash_rd;
    logic        stall_d;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    writeback_regfile dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reg_write_w_i   (reg_write_w),
        .result_src_w_i  (result_src_w),
        .alu_result_w_i  (alu_w),
        .read_data_w_i   (mem_w),
        .pc_plus4_w_i    (pc4_w),
        .imm_ext_w_i     (imm_w),
        .rd_w_i          (rd_w),
        .rs1_d_i         (rs1_d),
        .rs2_d_i         (rs2_d),
        .rd1_d_o         (rd1_d),
        .rd2_d_o         (rd2_d),
        .issue_valid_d_i (issue_valid),
        .issue_rd_d_i    (issue_rd),
        .squash_e_i      (squash_e),
        .squash_rd_e_i   (squash_rd),
        .result_w_o      (result_w),
        .stall_d_o       (stall_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: a 3-stage E/M/W pipeline of writers ----------------
    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu, mem, pc4, imm;
    } instr_t;

    instr_t      st_e, st_m, st_w;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rs, input logic [31:0] res);
        if (rs == 5'd0) return 32'd0;
        if (st_w.v && st_w.rd == rs) return res;
        return m_regs[rs];
    endfunction

    // A source stalls when a writer to it sits in E or M; one in W is bypassed.
    function automatic bit exp_stall_one(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        return (st_e.v && st_e.rd == rs) || (st_m.v && st_m.rd == rs);
    endfunction

    function automatic instr_t empty_instr();
        instr_t x;
        x.v = 0; x.rd = '0; x.src = '0; x.alu = '0; x.mem = '0; x.pc4 = '0; x.imm = '0;
        return x;
    endfunction

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 6));
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        st_e = empty_instr();
        st_m = empty_instr();
        st_w = empty_instr();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle of the random phase.
    always @(negedge clk) begin
        logic [31:0] er;
        #2;
        if (chk_en) begin
            er = sel(result_src_w, alu_w, mem_w, pc4_w, imm_w);
            chk("rand result_w", result_w, er);
            chk("rand rd1", rd1_d, exp_read(rs1_d, er));
            chk("rand rd2", rd2_d, exp_read(rs2_d, er));
            chk("rand stall", 32'(stall_d), 32'(exp_stall_one(rs1_d) || exp_stall_one(rs2_d)));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic idle();
        reg_write_w  = 0;
        result_src_w = 2'd0;
        alu_w = $urandom; mem_w = $urandom; pc4_w = $urandom; imm_w = $urandom;
        rd_w = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        issue_valid = 0; issue_rd = 5'd0;
        squash_e = 0; squash_rd = 5'd0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] val);
        reg_write_w  = 1;
        rd_w         = rd;
        result_src_w = src;
        case (src)
            2'd0:    alu_w = val;
            2'd1:    mem_w = val;
            2'd2:    pc4_w = val;
            default: imm_w = val;
        endcase
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_random(input int n);
        bit     sq;
        instr_t ni;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle();
            if (st_w.v) begin
                reg_write_w = 1; rd_w = st_w.rd; result_src_w = st_w.src;
                alu_w = st_w.alu; mem_w = st_w.mem; pc4_w = st_w.pc4; imm_w = st_w.imm;
            end else begin
                rd_w = pick_reg(); result_src_w = 2'($urandom_range(0, 3));
            end
            sq = st_e.v && ($urandom_range(0, 5) == 0);
            squash_e  = sq;
            squash_rd = sq ? st_e.rd : pick_reg();
            ni.v   = ($urandom_range(0, 2) != 0);
            ni.rd  = pick_reg();
            ni.src = 2'($urandom_range(0, 3));
            ni.alu = $urandom; ni.mem = $urandom; ni.pc4 = $urandom; ni.imm = $urandom;
            issue_valid = ni.v;
            issue_rd    = ni.rd;
            rs1_d = pick_reg();
            rs2_d = pick_reg();
            @(posedge clk);
            if (st_w.v && st_w.rd != 5'd0)
                m_regs[st_w.rd] = sel(st_w.src, st_w.alu, st_w.mem, st_w.pc4, st_w.imm);
            st_w = st_m;
            st_m = sq ? empty_instr() : st_e;
            st_e = ni.v ? ni : empty_instr();
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset values, then x5 written and reset asynchronously mid-cycle
        cyc(); rs1_d = 5'd5; issue_valid = 1; issue_rd = 5'd5; #1;
        chk("reset rd1", rd1_d, 32'd0);
        chk("reset stall", 32'(stall_d), 32'd0);
        cyc(); rs1_d = 5'd5; issue_valid = 1; issue_rd = 5'd6; #1;
        chk("x5 pending stall", 32'(stall_d), 32'd1);
        cyc(); wb(5'd5, 2'd0, 32'h0000_DEAD); rs1_d = 5'd6; #1;
        chk("x5 result_w", result_w, 32'h0000_DEAD);
        chk("x6 pending stall", 32'(stall_d), 32'd1);
        cyc(); rs1_d = 5'd5; #1;
        chk("x5 readback", rd1_d, 32'h0000_DEAD);
        #2 rst_n = 0;
        #1 chk("async reset rd1", rd1_d, 32'd0);
        rs1_d = 5'd6;
        #1 chk("async reset stall", 32'(stall_d), 32'd0);
        @(negedge clk); rst_n = 1;

        // x0 is never written
        cyc(); wb(5'd0, 2'd0, 32'hFFFF_FFFF); rs1_d = 5'd0; #1;
        chk("x0 result_w", result_w, 32'hFFFF_FFFF);
        chk("x0 rd1 same", rd1_d, 32'd0);
        cyc(); rs1_d = 5'd0; #1;
        chk("x0 rd1 next", rd1_d, 32'd0);
        chk("x0 stall", 32'(stall_d), 32'd0);

        // PC+4 select and write-first bypass on port 2
        cyc(); issue_valid = 1; issue_rd = 5'd7;
        cyc();
        cyc(); wb(5'd7, 2'd2, 32'h0000_0104); rs2_d = 5'd7; #1;
        chk("pc4 result_w", result_w, 32'h0000_0104);
        chk("x7 rd2 bypass", rd2_d, 32'h0000_0104);
        chk("x7 stall covered", 32'(stall_d), 32'd0);
        cyc(); rs2_d = 5'd7; #1;
        chk("x7 rd2 array", rd2_d, 32'h0000_0104);

        // Single writer to x3
        cyc(); issue_valid = 1; issue_rd = 5'd3; rs1_d = 5'd3; #1;
        chk("x3 issue cycle stall", 32'(stall_d), 32'd0);
        cyc(); rs1_d = 5'd3; #1;
        chk("x3 stall c1", 32'(stall_d), 32'd1);
        cyc(); rs1_d = 5'd3; #1;
        chk("x3 stall c2", 32'(stall_d), 32'd1);
        cyc(); wb(5'd3, 2'd0, 32'h0000_0033); rs1_d = 5'd3; #1;
        chk("x3 retire stall", 32'(stall_d), 32'd0);
        chk("x3 rd1 bypass", rd1_d, 32'h0000_0033);
        cyc(); rs1_d = 5'd3; #1;
        chk("x3 rd1 array", rd1_d, 32'h0000_0033);

        // Issue, retire and squash of x4 in one cycle
        cyc(); issue_valid = 1; issue_rd = 5'd4;
        cyc(); issue_valid = 1; issue_rd = 5'd4; squash_e = 1; squash_rd = 5'd4;
        wb(5'd4, 2'd3, 32'h0000_0044); rs1_d = 5'd4; #1;
        chk("x4 simul stall", 32'(stall_d), 32'd0);
        chk("x4 imm bypass", rd1_d, 32'h0000_0044);
        cyc(); rs1_d = 5'd4; #1;
        chk("x4 after stall", 32'(stall_d), 32'd0);

        // Two writers to x9
        cyc(); issue_valid = 1; issue_rd = 5'd9;
        cyc(); issue_valid = 1; issue_rd = 5'd9; rs1_d = 5'd9; #1;
        chk("x9 cnt1 stall", 32'(stall_d), 32'd1);
        cyc(); rs1_d = 5'd9; #1;
        chk("x9 cnt2 stall", 32'(stall_d), 32'd1);
        cyc(); wb(5'd9, 2'd1, 32'h0000_0091); rs1_d = 5'd9; #1;
        chk("x9 first retire stall", 32'(stall_d), 32'd1);
        chk("x9 mem bypass", rd1_d, 32'h0000_0091);
        cyc(); wb(5'd9, 2'd0, 32'h0000_0092); rs1_d = 5'd9; #1;
        chk("x9 second retire stall", 32'(stall_d), 32'd0);
        cyc(); rs1_d = 5'd9; #1;
        chk("x9 final rd1", rd1_d, 32'h0000_0092);
        chk("x9 final stall", 32'(stall_d), 32'd0);

        // Random pipeline traffic, with a reset that discards in-flight writers
        do_reset();
        model_clear();
        chk_en = 1;
        run_random(2500);
        chk_en = 0;
        do_reset();
        model_clear();
        chk_en = 1;
        run_random(2500);
        chk_en = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
